fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter CACHE_LINE_WIDTH, 64, line size in bytes.
REQ-002 Parameter SUPER_SCALAR_WIDTH, op_pkg::SUPER_SCALAR_WIDTH (2), lanes per bundle.
REQ-003 Parameter INSTRUCTION_WIDTH, op_pkg::INSTRUCTION_WIDTH (4), instruction size in bytes.
REQ-004 The block SHALL use one clock and a synchronous, active-low reset: clk_in  in  1  clock; rst_N_in  in  1  reset, active low, synchronous.
REQ-005 pc_valid_in  in  1  predictor presents a PC this cycle.
REQ-006 pred_pc_in  in  64  PC of the bundle.
REQ-007 l0_valid_in  in  1  l0_line_in holds the line (L0 hit).
REQ-008 l1i_wait_in  in  1  line will arrive later from L1I (L0 miss).
REQ-009 l0_line_in  in  CACHE_LINE_WIDTH*8  L0 line.
REQ-010 l1i_valid_in  in  1  L1I return valid.
REQ-011 l1i_line_in  in  CACHE_LINE_WIDTH*8  L1I line.
REQ-012 flush_in  in  1  execute misprediction (x_pc_incorrect).
REQ-013 decode_ready_in  in  1  decode accepts the bundle.
REQ-014 fetch_ready_out  out  1  ready to accept a PC.
REQ-015 bundle_valid_out  out  1  bundle valid to decode.
REQ-016 bundle_pc_out  out  64  PC of lane 0.
REQ-017 lane_valid_out  out  SUPER_SCALAR_WIDTH  per-lane valid.
REQ-018 lane_instr_out  out  SUPER_SCALAR_WIDTH x 32  per-lane instruction bits.
REQ-019 perf_bundles_out / perf_stalls_out  out  32 each  delivered-bundle / stall-cycle counters.

Function
REQ-020 FSM states SHALL be IDLE, WAIT_L1I, HOLD and DRAIN.
REQ-021 fetch_ready_out SHALL be 1 in IDLE, or in HOLD while decode_ready_in=1; 0 otherwise.
REQ-022 A PC SHALL be accepted when pc_valid_in and fetch_ready_out are both 1 and flush_in=0.
REQ-023 Accept with l0_valid_in=1: the bundle is extracted from l0_line_in and registered; bundle_valid_out=1 next cycle; state goes to HOLD.
REQ-024 Accept with l1i_wait_in=1: the PC is registered and the state goes to WAIT_L1I.
REQ-025 WAIT_L1I with l1i_valid_in=1: the bundle is extracted from l1i_line_in; bundle_valid_out=1 next cycle; state goes to HOLD.
REQ-026 Lane extraction: lane i byte offset = pc[5:0] + 4*i; the lane is valid iff offset <= CACHE_LINE_WIDTH - INSTRUCTION_WIDTH.
REQ-027 Lane extraction: instruction bits are little-endian bytes {b[off+3], b[off+2], b[off+1], b[off]}, where byte k = line[8k+7:8k]; invalid lanes drive 0.
REQ-028 HOLD: outputs are held stable until decode_ready_in=1.
REQ-029 HOLD on handshake: the state goes to IDLE; with a simultaneous accept, the new bundle is loaded back-to-back.
REQ-030 flush_in in HOLD or IDLE: bundle_valid_out is cleared next cycle and the state goes to IDLE; any PC on pc_valid_in that cycle is ignored.
REQ-031 flush_in in WAIT_L1I without l1i_valid_in: the state goes to DRAIN.
REQ-032 flush_in in WAIT_L1I together with l1i_valid_in: the return is discarded and the state goes to IDLE.
REQ-033 DRAIN: the next l1i_valid_in is discarded without output, then the state goes to IDLE; fetch_ready_out=0 while in DRAIN.
REQ-034 l1i_valid_in in IDLE or HOLD SHALL be ignored.
REQ-035 l0_valid_in and l1i_wait_in both 1 SHALL be treated as an L0 hit.
REQ-036 perf_bundles_out SHALL increment on each decode handshake.
REQ-037 perf_stalls_out SHALL increment each cycle in WAIT_L1I or DRAIN.
REQ-038 Both perf counters SHALL saturate at 32'hFFFFFFFF.

Reset
REQ-039 When rst_N_in=0 at a clock edge, the FSM SHALL go to IDLE; bundle_valid_out, lane_valid_out, lane_instr_out, bundle_pc_out, the stored PC and both counters SHALL be 0.
REQ-040 Reset mid-WAIT_L1I SHALL NOT enter DRAIN; a later stale return is dropped by REQ-034.

Structure
REQ-041 fetch_bundle_t (pc, lane_valid, lane_instr) SHALL live in op_pkg; the FSM state enum is local.
REQ-042 Lane slicing SHALL be one combinational sub-module, fetch_lane_extract, shared by the L0 and L1I paths via a 2:1 line mux.

Verification
REQ-043 L0 hit, pc=0x1000, line bytes 0..3=0x8B000020, decode_ready_in=1 -> next cycle bundle_valid_out=1, lane_instr_out[0]=0x8B000020, lane_valid_out=2'b11.
REQ-044 pc=0x103C on an L0 hit -> lane_valid_out=2'b01 (line-boundary truncation).
REQ-045 L1I miss, pc=0x2000, l1i_valid_in 5 cycles later -> fetch_ready_out=0 for 5 cycles, perf_stalls_out=5, bundle_valid_out 1 cycle after the return.
REQ-046 decode_ready_in=0 for 3 cycles -> outputs stable in HOLD; handshake on cycle 4 with a new pc=0x1008 L0 hit -> back-to-back bundle.
REQ-047 flush_in in WAIT_L1I, then l1i_valid_in 2 cycles later -> no bundle_valid_out, state IDLE, fetch_ready_out=1 afterward.
REQ-048 rst_N_in=0 for one cycle while in HOLD -> all outputs and counters 0; a subsequent stray l1i_valid_in produces no bundle.

Source files
------------

// File: rtl/op_pkg.sv
// rtl/op_pkg.sv - shared fetch-path widths, bundle type and counter helper
package op_pkg;

  localparam int SUPER_SCALAR_WIDTH = 2;
  localparam int INSTRUCTION_WIDTH  = 4;
  localparam int INSTR_BITS         = INSTRUCTION_WIDTH * 8;

  typedef struct packed {
    logic [63:0]                                     pc;
    logic [SUPER_SCALAR_WIDTH-1:0]                   lane_valid;
    logic [SUPER_SCALAR_WIDTH-1:0][INSTR_BITS-1:0]   lane_instr;
  } fetch_bundle_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_lane_extract.sv
// rtl/fetch_lane_extract.sv - slices consecutive little-endian instructions out of a cache line
module fetch_lane_extract
  import op_pkg::*;
#(
  parameter int LINE_BYTES  = 64,
  parameter int LANES       = SUPER_SCALAR_WIDTH,
  parameter int INSTR_BYTES = INSTRUCTION_WIDTH
) (
  input  logic [63:0]             pc,
  input  logic [LINE_BYTES*8-1:0] line,
  output fetch_bundle_t           bundle
);

  localparam int OFFW = $clog2(LINE_BYTES);
  localparam logic [OFFW:0] LAST_OFF = (OFFW+1)'(LINE_BYTES - INSTR_BYTES);

  // One extra offset bit so lanes past the end of the line compare as out of range.
  logic [OFFW:0] off;

  always_comb begin
    bundle    = '0;
    off       = '0;
    bundle.pc = pc;
    for (int i = 0; i < LANES; i++) begin
      off = {1'b0, pc[OFFW-1:0]} + (OFFW+1)'(i * INSTR_BYTES);
      if (off <= LAST_OFF) begin
        bundle.lane_valid[i] = 1'b1;
        bundle.lane_instr[i] = line[{off, 3'b000} +: INSTR_BITS];
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM: L0 hit / L1I miss handling, decode hold, flush drain
module fetch_unit #(
  parameter int CACHE_LINE_WIDTH   = 64,
  parameter int SUPER_SCALAR_WIDTH = op_pkg::SUPER_SCALAR_WIDTH,
  parameter int INSTRUCTION_WIDTH  = op_pkg::INSTRUCTION_WIDTH
) (
  input  logic                                 clk_in,
  input  logic                                 rst_N_in,
  input  logic                                 pc_valid_in,
  input  logic [63:0]                          pred_pc_in,
  input  logic                                 l0_valid_in,
  input  logic                                 l1i_wait_in,
  input  logic [CACHE_LINE_WIDTH*8-1:0]        l0_line_in,
  input  logic                                 l1i_valid_in,
  input  logic [CACHE_LINE_WIDTH*8-1:0]        l1i_line_in,
  input  logic                                 flush_in,
  input  logic                                 decode_ready_in,
  output logic                                 fetch_ready_out,
  output logic                                 bundle_valid_out,
  output logic [63:0]                          bundle_pc_out,
  output logic [SUPER_SCALAR_WIDTH-1:0]        lane_valid_out,
  output logic [SUPER_SCALAR_WIDTH-1:0][31:0]  lane_instr_out,
  output logic [31:0]                          perf_bundles_out,
  output logic [31:0]                          perf_stalls_out
);

  import op_pkg::*;

  typedef enum logic [1:0] {IDLE, WAIT_L1I, HOLD, DRAIN} state_t;

  state_t        state_q, state_d;
  fetch_bundle_t bundle_q, bundle_d, extracted;
  logic          bundle_valid_q, bundle_valid_d;
  logic [63:0]   pc_q, pc_d;
  logic [31:0]   perf_bundles_q, perf_stalls_q;
  logic          accept, handshake, use_l1i;
  logic [CACHE_LINE_WIDTH*8-1:0] line_mux;
  logic [63:0]   extract_pc;

  assign fetch_ready_out = (state_q == IDLE) || ((state_q == HOLD) && decode_ready_in);
  assign accept          = pc_valid_in && fetch_ready_out && !flush_in;
  assign handshake       = (state_q == HOLD) && decode_ready_in;

  // While waiting on L1I the extractor must use the PC captured at accept time.
  assign use_l1i    = (state_q == WAIT_L1I);
  assign line_mux   = use_l1i ? l1i_line_in : l0_line_in;
  assign extract_pc = use_l1i ? pc_q : pred_pc_in;

  fetch_lane_extract #(
    .LINE_BYTES  (CACHE_LINE_WIDTH),
    .LANES       (SUPER_SCALAR_WIDTH),
    .INSTR_BYTES (INSTRUCTION_WIDTH)
  ) u_lane_extract (
    .pc     (extract_pc),
    .line   (line_mux),
    .bundle (extracted)
  );

  always_comb begin
    state_d        = state_q;
    bundle_d       = bundle_q;
    bundle_valid_d = bundle_valid_q;
    pc_d           = pc_q;
    case (state_q)
      IDLE, HOLD: begin
        if (flush_in) begin
          state_d        = IDLE;
          bundle_valid_d = 1'b0;
        end else if (fetch_ready_out) begin
          state_d        = IDLE;
          bundle_valid_d = 1'b0;
          if (accept && l0_valid_in) begin
            bundle_d       = extracted;
            bundle_valid_d = 1'b1;
            state_d        = HOLD;
          end else if (accept && l1i_wait_in) begin
            pc_d    = pred_pc_in;
            state_d = WAIT_L1I;
          end
        end
      end
      WAIT_L1I: begin
        if (l1i_valid_in && flush_in) begin
          state_d = IDLE;
        end else if (l1i_valid_in) begin
          bundle_d       = extracted;
          bundle_valid_d = 1'b1;
          state_d        = HOLD;
        end else if (flush_in) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (l1i_valid_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      state_q        <= IDLE;
      bundle_q       <= '0;
      bundle_valid_q <= 1'b0;
      pc_q           <= '0;
      perf_bundles_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      state_q        <= state_d;
      bundle_q       <= bundle_d;
      bundle_valid_q <= bundle_valid_d;
      pc_q           <= pc_d;
      if (handshake) perf_bundles_q <= sat_inc(perf_bundles_q);
      if ((state_q == WAIT_L1I) || (state_q == DRAIN)) perf_stalls_q <= sat_inc(perf_stalls_q);
    end
  end

  assign bundle_valid_out = bundle_valid_q;
  assign bundle_pc_out    = bundle_q.pc;
  assign lane_valid_out   = bundle_q.lane_valid;
  assign lane_instr_out   = bundle_q.lane_instr;
  assign perf_bundles_out = perf_bundles_q;
  assign perf_stalls_out  = perf_stalls_q;

endmodule
